// File: rtl/mario_pkg.sv
// rtl/mario_pkg.sv - shared tile codes, geometry and vertical-state type for the Mario movers
package mario_pkg;

    typedef logic [7:0] tile_t;

    localparam tile_t SKY = 8'd1;
    localparam tile_t BLK = 8'd2;
    localparam tile_t GND = 8'd3;

    localparam int MARIO_WIDTH   = 42;
    localparam int SCREEN_HEIGHT = 480;
    localparam int SCREEN_WIDTH  = 680;
    localparam int BLOCK_WIDTH   = 40;
    localparam int MAP_ROWS      = 12;
    localparam int MAP_COLS      = 17;
    localparam int SPAWN_Y       = 358;
    localparam int JUMP_HEIGHT   = 100;
    localparam int MIN_JUMP      = 20;
    localparam int APEX_TICKS    = 6;

    typedef tile_t [MAP_ROWS-1:0][MAP_COLS-1:0] tile_map_t;

    typedef enum logic [2:0] {
        V_GROUNDED,
        V_RISING,
        V_APEX,
        V_FALLING,
        V_DEAD
    } vstate_t;

    function automatic logic is_solid(tile_t t);
        return (t == BLK) || (t == GND);
    endfunction

    function automatic int clamp_col(int c);
        if (c < 0) return 0;
        if (c > MAP_COLS - 1) return MAP_COLS - 1;
        return c;
    endfunction

endpackage

// File: rtl/mario_vertical_mover_if.sv
// rtl/mario_vertical_mover_if.sv - jump/map/position bundle between the game logic and the vertical mover
interface mario_vertical_mover_if;
    logic                jump;
    mario_pkg::tile_map_t background;
    int                  mario_x;
    int                  mario_y;
    logic                grounded;
    logic                dead;

    modport master (
        output jump, background, mario_x,
        input  mario_y, grounded, dead
    );

    modport slave (
        input  jump, background, mario_x,
        output mario_y, grounded, dead
    );
endinterface

// File: rtl/tile_probe.sv
// rtl/tile_probe.sv - reports whether either of two columns in one map row holds a solid tile
module tile_probe
    import mario_pkg::*;
(
    input  tile_map_t background_i,
    input  int        row_i,
    input  int        col_l_i,
    input  int        col_r_i,
    output logic      solid_any_o
);

    // Out-of-range rows or columns never count as solid, so Mario can leave the map.
    always_comb begin
        solid_any_o = 1'b0;
        if (row_i >= 0 && row_i < MAP_ROWS) begin
            if (col_l_i >= 0 && col_l_i < MAP_COLS)
                solid_any_o = solid_any_o | is_solid(background_i[row_i[3:0]][col_l_i[4:0]]);
            if (col_r_i >= 0 && col_r_i < MAP_COLS)
                solid_any_o = solid_any_o | is_solid(background_i[row_i[3:0]][col_r_i[4:0]]);
        end
    end

endmodule

// File: rtl/mario_vertical_mover.sv
// rtl/mario_vertical_mover.sv - per-tick vertical motion of Mario: jump, apex hang, gravity, landing, death
module mario_vertical_mover
    import mario_pkg::*;
(
    input  logic                  movement_clock,
    input  logic                  reset,
    mario_vertical_mover_if.slave bus
);

    vstate_t state_q, state_d;
    int      mario_y_q, mario_y_d;
    int      rise_cnt_q, rise_cnt_d;
    int      apex_cnt_q, apex_cnt_d;
    logic    jump_prev_q;

    int   col_l, col_r, row_below, row_above;
    logic below_solid, above_solid;
    logic support, head_hit, jump_edge;

    always_comb begin
        col_l     = clamp_col(bus.mario_x / BLOCK_WIDTH);
        col_r     = clamp_col((bus.mario_x + MARIO_WIDTH - 1) / BLOCK_WIDTH);
        row_below = (mario_y_q + MARIO_WIDTH) / BLOCK_WIDTH;
        row_above = (mario_y_q - 1) / BLOCK_WIDTH;
    end

    tile_probe u_probe_below (
        .background_i (bus.background),
        .row_i        (row_below),
        .col_l_i      (col_l),
        .col_r_i      (col_r),
        .solid_any_o  (below_solid)
    );

    tile_probe u_probe_above (
        .background_i (bus.background),
        .row_i        (row_above),
        .col_l_i      (col_l),
        .col_r_i      (col_r),
        .solid_any_o  (above_solid)
    );

    assign support   = below_solid;
    assign head_hit  = (mario_y_q <= 0) || above_solid;
    assign jump_edge = bus.jump & ~jump_prev_q;

    always_ff @(posedge movement_clock) begin
        if (reset) begin
            state_q     <= V_FALLING;
            mario_y_q   <= SPAWN_Y;
            rise_cnt_q  <= 0;
            apex_cnt_q  <= 0;
            jump_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mario_y_q   <= mario_y_d;
            rise_cnt_q  <= rise_cnt_d;
            apex_cnt_q  <= apex_cnt_d;
            jump_prev_q <= bus.jump;
        end
    end

    always_comb begin
        state_d    = state_q;
        mario_y_d  = mario_y_q;
        rise_cnt_d = rise_cnt_q;
        apex_cnt_d = apex_cnt_q;
        case (state_q)
            V_GROUNDED: begin
                if (jump_edge) begin
                    state_d    = V_RISING;
                    rise_cnt_d = 0;
                end else if (!support) begin
                    state_d = V_FALLING;
                end
            end
            V_RISING: begin
                // A ceiling ends the jump at once, even before MIN_JUMP, with no apex hang.
                if (head_hit) begin
                    state_d = V_FALLING;
                end else if (rise_cnt_q == JUMP_HEIGHT ||
                             (!bus.jump && rise_cnt_q >= MIN_JUMP)) begin
                    state_d    = V_APEX;
                    apex_cnt_d = 0;
                end else begin
                    mario_y_d  = mario_y_q - 1;
                    rise_cnt_d = rise_cnt_q + 1;
                end
            end
            V_APEX: begin
                apex_cnt_d = apex_cnt_q + 1;
                if (apex_cnt_q == APEX_TICKS - 1)
                    state_d = V_FALLING;
            end
            V_FALLING: begin
                if (mario_y_q + MARIO_WIDTH >= SCREEN_HEIGHT)
                    state_d = V_DEAD;
                else if (support)
                    state_d = V_GROUNDED;
                else
                    mario_y_d = mario_y_q + 1;
            end
            V_DEAD: begin
                state_d = V_DEAD;
            end
            default: begin
                state_d = V_FALLING;
            end
        endcase
    end

    always_comb begin
        bus.mario_y  = mario_y_q;
        bus.grounded = (state_q == V_GROUNDED);
        bus.dead     = (state_q == V_DEAD);
    end

endmodule

// File: tb/tb_mario_vertical_mover.sv
// tb/tb_mario_vertical_mover.sv - scoreboard bench for the vertical mover against a tick-level reference model
module tb_mario_vertical_mover;

    localparam int M_GND  = 0;
    localparam int M_RISE = 1;
    localparam int M_APEX = 2;
    localparam int M_FALL = 3;
    localparam int M_DEAD = 4;

    typedef struct {
        int y;
        bit g;
        bit d;
    } exp_t;

    logic clk;
    logic rst;
    logic [7:0] bg [12][17];

    mario_vertical_mover_if mv ();

    mario_vertical_mover dut (
        .movement_clock (clk),
        .reset          (rst),
        .bus            (mv)
    );

    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    int m_st, m_y, m_rise, m_apex;
    bit m_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_map();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                mv.background[r][c] = bg[r][c];
    endtask

    function automatic bit solid_at(int r, int c);
        if (r < 0 || r > 11 || c < 0 || c > 16) return 1'b0;
        return (bg[r][c] == 8'd2) || (bg[r][c] == 8'd3);
    endfunction

    function automatic int clampc(int c);
        if (c < 0) return 0;
        if (c > 16) return 16;
        return c;
    endfunction

    task automatic model_step(output exp_t e);
        int cl, cr, rb, ra;
        bit sup, hh, je;
        cl  = clampc(mv.mario_x / 40);
        cr  = clampc((mv.mario_x + 41) / 40);
        rb  = (m_y + 42) / 40;
        ra  = (m_y - 1) / 40;
        sup = solid_at(rb, cl) || solid_at(rb, cr);
        hh  = (m_y <= 0) || solid_at(ra, cl) || solid_at(ra, cr);
        je  = mv.jump && !m_prev;
        if (rst) begin
            m_st = M_FALL; m_y = 358; m_rise = 0; m_apex = 0; m_prev = 1'b0;
        end else begin
            case (m_st)
                M_GND: begin
                    if (je) begin m_st = M_RISE; m_rise = 0; end
                    else if (!sup) m_st = M_FALL;
                end
                M_RISE: begin
                    if (hh) m_st = M_FALL;
                    else if (m_rise == 100 || (!mv.jump && m_rise >= 20)) begin
                        m_st = M_APEX; m_apex = 0;
                    end else begin
                        m_y = m_y - 1; m_rise = m_rise + 1;
                    end
                end
                M_APEX: begin
                    if (m_apex == 5) m_st = M_FALL;
                    m_apex = m_apex + 1;
                end
                M_FALL: begin
                    if (m_y + 42 >= 480) m_st = M_DEAD;
                    else if (sup) m_st = M_GND;
                    else m_y = m_y + 1;
                end
                default: m_st = M_DEAD;
            endcase
            m_prev = mv.jump;
        end
        e.y = m_y;
        e.g = (m_st == M_GND);
        e.d = (m_st == M_DEAD);
    endtask

    task automatic tick();
        exp_t e;
        model_step(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("mario_y", mv.mario_y, e.y);
        check_eq("grounded", int'(mv.grounded), int'(e.g));
        check_eq("dead", int'(mv.dead), int'(e.d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int min_y, cnt, hits;
        n_cmp = 0;
        n_err = 0;
        m_st = M_FALL; m_y = 0; m_rise = 0; m_apex = 0; m_prev = 1'b0;

        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                bg[r][c] = (r == 10) ? 8'd3 : 8'd1;
        drive_map();
        mv.mario_x = 100;
        mv.jump    = 1'b0;
        rst        = 1'b1;

        tick();
        check_eq("reset_y", mv.mario_y, 358);
        check_eq("reset_grounded", int'(mv.grounded), 0);
        check_eq("reset_dead", int'(mv.dead), 0);
        rst = 1'b0;
        tick();
        check_eq("land_grounded", int'(mv.grounded), 1);
        check_eq("land_y", mv.mario_y, 358);

        // single-tick press: minimum jump
        mv.jump = 1'b1;
        tick();
        mv.jump = 1'b0;
        min_y = 1000; cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (mv.mario_y < min_y) min_y = mv.mario_y;
            if (mv.mario_y == 338) cnt++;
        end
        check_eq("min_jump_peak", min_y, 338);
        check_eq("min_jump_peak_ticks", cnt, 8);
        check_eq("min_jump_land_y", mv.mario_y, 358);
        check_eq("min_jump_land_g", int'(mv.grounded), 1);

        // held jump: full height, no retrigger while held
        mv.jump = 1'b1;
        min_y = 1000;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (mv.mario_y < min_y) min_y = mv.mario_y;
        end
        check_eq("full_jump_peak", min_y, 258);
        check_eq("held_no_retrigger_y", mv.mario_y, 358);
        check_eq("held_no_retrigger_g", int'(mv.grounded), 1);
        mv.jump = 1'b0;
        tick();
        mv.jump = 1'b1;
        tick();
        mv.jump = 1'b0;
        tick();
        tick();
        check_eq("repress_rise_y", mv.mario_y, 356);
        for (int i = 0; i < 80; i++) tick();
        check_eq("repress_land_g", int'(mv.grounded), 1);

        // ceiling block at row 7
        bg[7][2] = 8'd2; bg[7][3] = 8'd2;
        drive_map();
        mv.jump = 1'b1;
        min_y = 1000; hits = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (mv.mario_y < min_y) min_y = mv.mario_y;
            if (mv.mario_y == 320) hits++;
        end
        check_eq("head_hit_peak", min_y, 320);
        check_eq("head_hit_no_hang", hits, 2);
        check_eq("head_hit_land_y", mv.mario_y, 358);
        mv.jump = 1'b0;
        bg[7][2] = 8'd1; bg[7][3] = 8'd1;
        drive_map();
        tick();

        // walk-off into pit, death, reset recovery
        bg[10][2] = 8'd1; bg[10][3] = 8'd1;
        drive_map();
        for (int i = 0; i < 100; i++) tick();
        check_eq("dead_flag", int'(mv.dead), 1);
        check_eq("dead_y", mv.mario_y, 438);
        bg[10][2] = 8'd3; bg[10][3] = 8'd3;
        drive_map();
        rst = 1'b1;
        tick();
        check_eq("dead_reset_y", mv.mario_y, 358);
        check_eq("dead_reset_dead", int'(mv.dead), 0);
        rst = 1'b0;
        tick();
        check_eq("respawn_grounded", int'(mv.grounded), 1);

        // reset in the middle of a rise
        mv.jump = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mv.mario_y == 300) break;
        end
        check_eq("reach_300", mv.mario_y, 300);
        rst = 1'b1;
        tick();
        check_eq("midrise_reset_y", mv.mario_y, 358);
        check_eq("midrise_reset_g", int'(mv.grounded), 0);
        rst = 1'b0;
        mv.jump = 1'b0;
        tick();
        check_eq("midrise_relanded_g", int'(mv.grounded), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
